cic_conv_sequencer: RTL and testbench
=====================================

Name: cic_conv_sequencer

Overview:
Controls repeated one-shot conversions of the upstream 2nd-order CIC decimator and consumes its results. Per conversion it pulses the decimator reset, waits for its done flag, and captures the 19-bit result. It accumulates a programmable number of conversions, 1 to 8, for noise averaging. The sum is presented downstream on a valid/ready handshake. A timeout flags a decimator that never finishes.

Parameters:
DATA_W, 19, width of the decimator result.
NCONV_W, 3, width of the conversion-count input; conversions = n_conv_in + 1.
ACC_W, DATA_W+NCONV_W (22), accumulator and output width.
RST_CYC, 4, cycles the decimator reset is held per conversion; must be >= 2.
TIMEOUT_CYC, 2048, maximum cycles spent in WAIT before the error flag is set.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_in  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a conversion batch; sampled only in IDLE.
n_conv_in  in  NCONV_W  conversions per batch minus one; latched on an accepted start.
cic_rst_out  out  1  reset to the decimator (active-high).
cic_done_in  in  1  decimator done flag; produced on the falling edge.
cic_data_in  in  DATA_W  decimator result, unsigned; stable while done is high.
acc_out  out  ACC_W  accumulated batch result.
out_valid  out  1  acc_out is valid.
out_ready  in  1  downstream accepts acc_out.
busy  out  1  high in every state except IDLE.
err  out  1  sticky timeout flag.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst_in. cic_done_in is registered once into done_q on the rising edge; only done_q is used internally.
- Reset values:
  - state = IDLE; cic_rst_out = 1; acc_out = 0; out_valid = 0; busy = 0; err = 0.
  - All counters = 0.
  - Reset mid-operation aborts the batch immediately; no partial result is output.
- States: IDLE, RST, WAIT, CAPTURE, OUT.
- IDLE:
  - cic_rst_out = 1.
  - start = 1 → latch n_conv_in into n_lat, clear acc and conv_cnt, clear err, go to RST.
  - start is ignored in every state other than IDLE.
- RST:
  - cic_rst_out = 1 for exactly RST_CYC cycles, counted by rst_cnt; then go to WAIT.
  - Because RST_CYC >= 2, done_q is guaranteed low on entry to WAIT.
- WAIT:
  - cic_rst_out = 0; wait_cnt increments every cycle.
  - done_q = 1 → go to CAPTURE.
  - Else, when wait_cnt reaches TIMEOUT_CYC-1 → set err = 1 and go to IDLE. acc is discarded and out_valid is not raised.
  - If done_q and the timeout occur in the same cycle, done wins.
- CAPTURE (exactly 1 cycle):
  - cic_rst_out = 0.
  - acc <= acc + zero-extended cic_data_in. No overflow is possible: 8 × (2^19 − 1) < 2^22.
  - conv_cnt == n_lat → go to OUT, with acc_out loaded with the final sum.
  - Otherwise increment conv_cnt and go to RST.
- OUT:
  - cic_rst_out = 1; out_valid = 1; acc_out held stable.
  - out_ready = 1 → transfer completes; out_valid = 0 in the next cycle; go to IDLE.
  - A start that arrives in the same cycle as the handshake is ignored.
- Latency:
  - The first cic_rst_out assertion is the cycle after start.
  - Per conversion: RST_CYC (RST) + (decimator run + 1 for done_q) (WAIT) + 1 (CAPTURE).
  - out_valid rises the cycle after the last CAPTURE.
- acc_out changes only on entry to OUT and is held in IDLE until the next batch completes.
- busy = (state != IDLE).
- err clears only on reset or an accepted start.

Decomposition:
- Shared package cic_pkg holds:
  - the state enum (IDLE, RST, WAIT, CAPTURE, OUT);
  - the DATA_W = 19 constant, shared with the decimator;
  - default RST_CYC and TIMEOUT_CYC.
- One natural sub-module: cic_seq_timer, a loadable down-counter with a terminal flag. It is instantiated for both the RST hold and the WAIT timeout.
- Everything else lives in the top FSM.

Test Plan:
- Bench uses a behavioural decimator stub: done rises 20 cycles after rst falls; data is taken from a list.
- Single conversion: n_conv_in = 0, stub data 12345 → out_valid = 1 with acc_out = 12345; cic_rst_out high for exactly 4 cycles; out_valid rises the cycle after CAPTURE.
- Averaging: n_conv_in = 3, stub data 100, 200, 300, 400 → 4 reset pulses observed; acc_out = 1000; no intermediate out_valid.
- Max width: n_conv_in = 7, all data 0x7FFFF → acc_out = 0x3FFFF8, with no wrap.
- Backpressure and ignored start:
  - out_ready held low 10 cycles → out_valid and acc_out stay stable; then 1-cycle ready → out_valid falls the next cycle, busy = 0.
  - A start pulsed during WAIT is ignored.
- Timeout: stub never asserts done, TIMEOUT_CYC = 64 → err = 1 after 64 WAIT cycles, returns to IDLE, out_valid never asserted. A following start clears err.
- Reset mid-WAIT: rst_in pulsed during conversion 2 of 4 → next cycle shows cic_rst_out = 1, busy = 0, out_valid = 0, acc_out = 0. A fresh batch afterwards produces the correct sum.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC conversion sequencer.
// DATA_W is shared with the upstream 2nd-order CIC decimator.
// Contents: the sequencer state enum, DATA_W, and default reset-hold and timeout lengths.
package cic_pkg;

  localparam int unsigned DATA_W          = 19;
  localparam int unsigned RST_CYC_DEF     = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 2048;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StWait,
    StCapture,
    StOut
  } state_e;

endpackage

// File: rtl/cic_seq_timer.sv
// Loadable down-counter with a terminal-count flag.
// Ports:
//   clk_i      - clock
//   rst_i      - synchronous active-high reset (count cleared to 0)
//   load_i     - load load_val_i (has priority over counting)
//   load_val_i - value to load
//   en_i       - decrement enable; the count saturates at 0
//   tc_o       - high while the count is 0
module cic_seq_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);
  import cic_pkg::*;

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/cic_conv_sequencer.sv
// Sequencer for repeated one-shot conversions of a CIC decimator.
// Each conversion pulses the decimator reset, waits for its done flag and then adds the result to
// an accumulator. After n_conv_in+1 conversions, the sum is offered on a valid/ready interface.
// A decimator that never finishes sets a sticky err flag and aborts the batch.
// Ports:
//   clk, rst_in            - clock, synchronous active-high reset
//   start, n_conv_in       - batch request (sampled in IDLE only), conversions minus one
//   cic_rst_out            - decimator reset (active-high)
//   cic_done_in            - decimator done flag (registered once before use)
//   cic_data_in            - decimator result, unsigned
//   acc_out, out_valid     - batch sum and its valid flag
//   out_ready              - downstream accept
//   busy, err              - not-idle flag, sticky timeout flag
module cic_conv_sequencer #(
  parameter int unsigned DATA_W      = cic_pkg::DATA_W,
  parameter int unsigned NCONV_W     = 3,
  parameter int unsigned ACC_W       = DATA_W + NCONV_W,
  parameter int unsigned RST_CYC     = cic_pkg::RST_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = cic_pkg::TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               start,
  input  logic [NCONV_W-1:0] n_conv_in,
  output logic               cic_rst_out,
  input  logic               cic_done_in,
  input  logic [DATA_W-1:0]  cic_data_in,
  output logic [ACC_W-1:0]   acc_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err
);
  import cic_pkg::*;

  localparam int unsigned RstW  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int unsigned WaitW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e               state_q, state_d;
  logic [NCONV_W-1:0]   n_lat_q, n_lat_d;
  logic [NCONV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     acc_out_q, acc_out_d;
  logic                 err_q, err_d;
  logic                 done_q;
  logic                 rst_tc, wait_tc;

  // Both timers reload continuously outside their own state, so each holds its full count on
  // the first cycle of that state and reaches 0 on its last cycle.
  cic_seq_timer #(
    .Width(RstW)
  ) u_rst_timer (
    .clk_i      (clk),
    .rst_i      (rst_in),
    .load_i     (state_q != StRst),
    .load_val_i (RstW'(RST_CYC - 1)),
    .en_i       (1'b1),
    .tc_o       (rst_tc)
  );

  cic_seq_timer #(
    .Width(WaitW)
  ) u_wait_timer (
    .clk_i      (clk),
    .rst_i      (rst_in),
    .load_i     (state_q != StWait),
    .load_val_i (WaitW'(TIMEOUT_CYC - 1)),
    .en_i       (1'b1),
    .tc_o       (wait_tc)
  );

  always_comb begin
    state_d    = state_q;
    n_lat_d    = n_lat_q;
    conv_cnt_d = conv_cnt_q;
    acc_d      = acc_q;
    acc_out_d  = acc_out_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_lat_d    = n_conv_in;
          conv_cnt_d = '0;
          acc_d      = '0;
          err_d      = 1'b0;
          state_d    = StRst;
        end
      end
      StRst: begin
        if (rst_tc) state_d = StWait;
      end
      StWait: begin
        // done takes precedence over a coincident timeout
        if (done_q) begin
          state_d = StCapture;
        end else if (wait_tc) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCapture: begin
        acc_d = acc_q + ACC_W'(cic_data_in);
        if (conv_cnt_q == n_lat_q) begin
          acc_out_d = acc_d;
          state_d   = StOut;
        end else begin
          conv_cnt_d = conv_cnt_q + NCONV_W'(1);
          state_d    = StRst;
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= StIdle;
      n_lat_q    <= '0;
      conv_cnt_q <= '0;
      acc_q      <= '0;
      acc_out_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_lat_q    <= n_lat_d;
      conv_cnt_q <= conv_cnt_d;
      acc_q      <= acc_d;
      acc_out_q  <= acc_out_d;
      err_q      <= err_d;
      done_q     <= cic_done_in;
    end
  end

  assign cic_rst_out = (state_q == StIdle) || (state_q == StRst) || (state_q == StOut);
  assign out_valid   = (state_q == StOut);
  assign busy        = (state_q != StIdle);
  assign acc_out     = acc_out_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cic_conv_sequencer.sv
// Directed self-checking bench for cic_conv_sequencer with a behavioural decimator stub.
module tb_cic_conv_sequencer;

  logic        clk;
  logic        rst_in;
  logic        start;
  logic [2:0]  n_conv_in;
  logic        cic_rst_out;
  logic        cic_done_in;
  logic [18:0] cic_data_in;
  logic [21:0] acc_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  cic_conv_sequencer #(
    .TIMEOUT_CYC(64)
  ) dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .start       (start),
    .n_conv_in   (n_conv_in),
    .cic_rst_out (cic_rst_out),
    .cic_done_in (cic_done_in),
    .cic_data_in (cic_data_in),
    .acc_out     (acc_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimator stub: done rises on the 20th falling edge after its reset drops; the result index
  // advances each time the reset re-asserts after a completed conversion.
  logic [18:0] data_list [8];
  logic        stub_clr;
  logic        stub_hang;
  int          stub_idx;
  int          stub_cnt;

  always @(negedge clk) begin
    if (stub_clr) begin
      stub_idx    <= 0;
      stub_cnt    <= 0;
      cic_done_in <= 1'b0;
    end else if (cic_rst_out) begin
      if (cic_done_in) stub_idx <= stub_idx + 1;
      stub_cnt    <= 0;
      cic_done_in <= 1'b0;
    end else if (!stub_hang && stub_cnt < 20) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == 19) cic_done_in <= 1'b1;
    end
  end

  assign cic_data_in = data_list[stub_idx[2:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stub();
    stub_clr = 1'b1;
    step();
    stub_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] n);
    start     = 1'b1;
    n_conv_in = n;
    step();
    start     = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic wait_for_valid(input int budget, output int cycles, output int falls,
                                output bit seen);
    logic prev;
    prev   = cic_rst_out;
    cycles = 0;
    falls  = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      step();
      cycles++;
      if (prev && !cic_rst_out) falls++;
      prev = cic_rst_out;
      seen = out_valid;
    end
  endtask

  int cycles, falls, hi, bad;
  bit seen;

  initial begin
    rst_in    = 1'b1;
    start     = 1'b0;
    n_conv_in = 3'd0;
    out_ready = 1'b0;
    stub_clr  = 1'b1;
    stub_hang = 1'b0;
    for (int i = 0; i < 8; i++) data_list[i] = 19'd0;
    step();
    step();
    check_eq("rst_cic_rst", cic_rst_out, 1);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_acc", acc_out, 0);
    rst_in   = 1'b0;
    stub_clr = 1'b0;
    step();

    // Single conversion: 4-cycle reset hold, fixed latency to out_valid
    data_list[0] = 19'd12345;
    clear_stub();
    pulse_start(3'd0);
    hi = 0;
    while (cic_rst_out && hi < 50) begin
      hi++;
      step();
    end
    check_eq("single_rst_hold", hi, 4);
    wait_for_valid(500, cycles, falls, seen);
    check_eq("single_seen", seen, 1);
    check_eq("single_latency", cycles, 22);
    check_eq("single_acc", acc_out, 12345);
    accept();
    check_eq("single_valid_drop", out_valid, 0);

    // Averaging over four conversions
    data_list[0] = 19'd100;
    data_list[1] = 19'd200;
    data_list[2] = 19'd300;
    data_list[3] = 19'd400;
    clear_stub();
    pulse_start(3'd3);
    wait_for_valid(2000, cycles, falls, seen);
    check_eq("avg_seen", seen, 1);
    check_eq("avg_pulses", falls, 4);
    check_eq("avg_acc", acc_out, 1000);
    accept();

    // Eight full-scale conversions, no wrap
    for (int i = 0; i < 8; i++) data_list[i] = 19'h7FFFF;
    clear_stub();
    pulse_start(3'd7);
    wait_for_valid(4000, cycles, falls, seen);
    check_eq("max_seen", seen, 1);
    check_eq("max_pulses", falls, 8);
    check_eq("max_acc", acc_out, 32'h3FFFF8);
    accept();

    // Start pulsed during WAIT is ignored, then backpressure
    data_list[0] = 19'd7;
    data_list[1] = 19'd8;
    clear_stub();
    pulse_start(3'd1);
    for (int i = 0; i < 10; i++) step();
    check_eq("ign_in_wait", cic_rst_out, 0);
    pulse_start(3'd0);
    wait_for_valid(2000, cycles, falls, seen);
    check_eq("ign_seen", seen, 1);
    check_eq("ign_acc", acc_out, 15);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b1 || acc_out !== 22'd15 || busy !== 1'b1) bad++;
    end
    check_eq("bp_stable", bad, 0);
    accept();
    check_eq("bp_valid_drop", out_valid, 0);
    check_eq("bp_busy_drop", busy, 0);
    check_eq("bp_acc_held", acc_out, 15);

    // Timeout: decimator never finishes
    stub_hang = 1'b1;
    clear_stub();
    pulse_start(3'd0);
    cycles = 0;
    bad    = 0;
    while (busy && cycles < 300) begin
      step();
      cycles++;
      if (out_valid) bad++;
    end
    check_eq("to_cycles", cycles, 68);
    check_eq("to_err", err, 1);
    check_eq("to_no_valid", bad, 0);
    check_eq("to_idle_rst", cic_rst_out, 1);
    check_eq("to_acc_held", acc_out, 15);
    stub_hang = 1'b0;
    data_list[0] = 19'd55;
    clear_stub();
    check_eq("to_err_sticky", err, 1);
    pulse_start(3'd0);
    check_eq("to_err_clear", err, 0);
    wait_for_valid(500, cycles, falls, seen);
    check_eq("to_recover_acc", acc_out, 55);
    accept();

    // Reset during the second of four conversions
    data_list[0] = 19'd10;
    data_list[1] = 19'd20;
    data_list[2] = 19'd30;
    data_list[3] = 19'd40;
    clear_stub();
    pulse_start(3'd3);
    falls = 0;
    cycles = 0;
    begin
      logic prev;
      prev = cic_rst_out;
      while (falls < 2 && cycles < 500) begin
        step();
        cycles++;
        if (prev && !cic_rst_out) falls++;
        prev = cic_rst_out;
      end
    end
    check_eq("mid_reached_conv2", falls, 2);
    for (int i = 0; i < 5; i++) step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_eq("mid_cic_rst", cic_rst_out, 1);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_valid", out_valid, 0);
    check_eq("mid_acc", acc_out, 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid || busy) bad++;
    end
    check_eq("mid_stays_idle", bad, 0);
    clear_stub();
    pulse_start(3'd3);
    wait_for_valid(2000, cycles, falls, seen);
    check_eq("mid_fresh_seen", seen, 1);
    check_eq("mid_fresh_acc", acc_out, 100);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
